// File: rtl/neuron_mac_pkg.sv
// Shared constants and FSM encoding for the neuron pre-activation MAC stage.
package neuron_mac_pkg;

    localparam int WIDTH_D = 32;
    localparam int FL_D    = 24;
    localparam int GUARD_D = 8;

    localparam logic [31:0] ONE     = 32'h0100_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_FLUSH,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/neuron_mac_if.sv
// Control/operand/result bundle between the layer controller and one neuron MAC.
interface neuron_mac_if
    import neuron_mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_D
);
    logic             start;
    logic [WIDTH-1:0] bias;
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] w;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] y;

    modport master (
        output start, bias, in_valid, x, w,
        input  busy, out_valid, y
    );

    modport slave (
        input  start, bias, in_valid, x, w,
        output busy, out_valid, y
    );
endinterface

// File: rtl/neuron_mac_fx_mul.sv
// Registered signed fixed-point multiply: product floored by FL fractional bits.
module fx_mul
    import neuron_mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int FL    = FL_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic                    clr,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic [2*WIDTH-FL-1:0]   p
);
    localparam int PW = 2 * WIDTH - FL;

    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;

    assign ax = {{WIDTH{a[WIDTH-1]}}, a};
    assign bx = {{WIDTH{b[WIDTH-1]}}, b};

    // Arithmetic shift floors toward minus infinity; upper bits are pure sign copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            if (clr)
                p <= '0;
            else if (load)
                p <= PW'((ax * bx) >>> FL);
        end
    end
endmodule

// File: rtl/neuron_mac.sv
// Serial MAC computing y = sat(bias + sum x[i]*w[i]) over N_INPUTS Q8.24 operand pairs.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int WIDTH    = WIDTH_D,
    parameter int FL       = FL_D,
    parameter int N_INPUTS = 4,
    parameter int GUARD    = GUARD_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    neuron_mac_if.slave  bus
);
    localparam int PW    = 2 * WIDTH - FL;
    localparam int ACC_W = PW + GUARD;
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             start_ok;
    logic             busy;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    prod;
    logic             prod_valid;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] bias_q;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic [ACC_W:0]   sum;
    logic             fits;
    logic [WIDTH-1:0] sat_y;

    assign last = (cnt == CNT_W'(N_INPUTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        start_ok  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (last)
                        state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH:  state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    fx_mul #(
        .WIDTH (WIDTH),
        .FL    (FL)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (accept),
        .clr  (start_ok),
        .a    (bus.x),
        .b    (bus.w),
        .p    (prod)
    );

    // One extra bit so bias can never wrap the sum before the range check.
    assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - WIDTH){bias_q[WIDTH-1]}}, bias_q};
    assign fits = (sum[ACC_W:WIDTH-1] == '0) || (sum[ACC_W:WIDTH-1] == '1);

    always_comb begin
        sat_y = sum[WIDTH-1:0];
        if (!fits)
            sat_y = sum[ACC_W] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end

    // The product register lags acceptance by one cycle, so the add is keyed on prod_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            bias_q     <= '0;
            prod_valid <= 1'b0;
            out_valid  <= 1'b0;
            y          <= '0;
        end else if (en) begin
            out_valid  <= (state == ST_FINISH);
            prod_valid <= accept;
            if (start_ok) begin
                acc    <= '0;
                cnt    <= '0;
                bias_q <= bus.bias;
            end else begin
                if (prod_valid)
                    acc <= acc + {{GUARD{prod[PW-1]}}, prod};
                if (accept)
                    cnt <= last ? '0 : cnt + 1'b1;
            end
            if (state == ST_FINISH)
                y <= sat_y;
        end
    end

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.y         = y;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: nominal, bubbles, saturation, truncation, reset, stall, back-to-back.
module tb_neuron_mac;
    import neuron_mac_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;

    neuron_mac_if #(.WIDTH(32)) bus ();

    neuron_mac #(
        .WIDTH    (32),
        .FL       (24),
        .N_INPUTS (4),
        .GUARD    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] vx [4];
    logic [31:0] vw [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nominal();
        vx[0] = 32'h0100_0000; vw[0] = 32'h0080_0000;
        vx[1] = 32'h0200_0000; vw[1] = 32'h0040_0000;
        vx[2] = 32'hFF80_0000; vw[2] = 32'h0100_0000;
        vx[3] = 32'h0040_0000; vw[3] = 32'hFE00_0000;
    endtask

    // Drives one full operation from IDLE; lat counts cycles from the last beat to out_valid.
    task automatic run_op(input logic [31:0] b, input int gap, output logic [31:0] y_o, output int lat);
        bus.start = 1'b1;
        bus.bias  = b;
        step();
        bus.start = 1'b0;
        bus.bias  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.x = vx[i];
            bus.w = vw[i];
            step();
            bus.in_valid = 1'b0;
            bus.x = '0;
            bus.w = '0;
            if (i < 3) repeat (gap) step();
        end
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        y_o = bus.y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        bus.start = 1'b0; bus.bias = '0; bus.in_valid = 1'b0; bus.x = '0; bus.w = '0;
        repeat (2) step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", bus.y); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        logic [31:0] yv;
        int lat;
        load_nominal();
        run_op(32'h0080_0000, 0, yv, lat);
        checks++; if (yv !== 32'h0080_0000) begin errors++; $display("FAIL nominal_y got %h want 00800000", yv); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL nominal_latency got %0d want 3", lat); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nominal_pulse_width got %0b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after got %0b want 0", bus.busy); end
        checks++; if (bus.y !== 32'h0080_0000) begin errors++; $display("FAIL nominal_y_held got %h want 00800000", bus.y); end
    endtask

    task automatic test_bubbles();
        logic [31:0] yv;
        int lat;
        load_nominal();
        run_op(32'h0080_0000, 2, yv, lat);
        checks++; if (yv !== 32'h0080_0000) begin errors++; $display("FAIL bubbles_y got %h want 00800000", yv); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL bubbles_latency got %0d want 3", lat); end
        step();
    endtask

    task automatic test_saturation();
        logic [31:0] yv;
        int lat;
        for (int i = 0; i < 4; i++) begin vx[i] = 32'h7F00_0000; vw[i] = 32'h7F00_0000; end
        run_op(32'h0, 0, yv, lat);
        checks++; if (yv !== SAT_MAX) begin errors++; $display("FAIL sat_pos got %h want %h", yv, SAT_MAX); end
        step();
        for (int i = 0; i < 4; i++) vw[i] = 32'h8100_0000;
        run_op(32'h0, 0, yv, lat);
        checks++; if (yv !== SAT_MIN) begin errors++; $display("FAIL sat_neg got %h want %h", yv, SAT_MIN); end
        step();
    endtask

    task automatic test_rst_mid();
        logic [31:0] yv;
        int lat;
        int pulses;
        load_nominal();
        bus.start = 1'b1; bus.bias = 32'h0080_0000;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.x = vx[i]; bus.w = vw[i];
            step();
        end
        bus.x = vx[2]; bus.w = vw[2];
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", bus.busy); end
        checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL rst_mid_y got %h want 00000000", bus.y); end
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            bus.x = vx[i % 4]; bus.w = vw[i % 4];
            step();
            if (bus.out_valid === 1'b1) pulses++;
        end
        bus.in_valid = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_pulse got %0d pulses want 0", pulses); end
        run_op(32'h0080_0000, 0, yv, lat);
        checks++; if (yv !== 32'h0080_0000) begin errors++; $display("FAIL rst_mid_fresh_y got %h want 00800000", yv); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid_fresh_latency got %0d want 3", lat); end
        step();
    endtask

    task automatic test_truncation();
        logic [31:0] yv;
        int lat;
        for (int i = 0; i < 4; i++) begin vx[i] = '0; vw[i] = '0; end
        vx[0] = 32'hFFFF_FFFF; vw[0] = 32'h0000_0001;
        run_op(32'h0, 0, yv, lat);
        checks++; if (yv !== 32'hFFFF_FFFF) begin errors++; $display("FAIL trunc_floor got %h want ffffffff", yv); end
        step();
        vx[0] = 32'h0000_0001;
        run_op(32'h0, 0, yv, lat);
        checks++; if (yv !== 32'h0) begin errors++; $display("FAIL trunc_pos got %h want 00000000", yv); end
        step();
    endtask

    task automatic test_stall();
        int t;
        logic [31:0] yv;
        load_nominal();
        bus.start = 1'b1; bus.bias = 32'h0080_0000;
        step();
        bus.start = 1'b0; bus.bias = '0;
        t = 1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.x = vx[i]; bus.w = vw[i];
            step(); t++;
        end
        en = 1'b0;
        bus.start = 1'b1; bus.bias = 32'h7F00_0000;
        bus.x = 32'h7F00_0000; bus.w = 32'h7F00_0000;
        repeat (3) begin step(); t++; end
        en = 1'b1;
        for (int i = 2; i < 4; i++) begin
            bus.x = vx[i]; bus.w = vw[i];
            step(); t++;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0; bus.x = '0; bus.w = '0; bus.bias = '0;
        while (bus.out_valid !== 1'b1 && t < 30) begin step(); t++; end
        yv = bus.y;
        checks++; if (yv !== 32'h0080_0000) begin errors++; $display("FAIL stall_y got %h want 00800000", yv); end
        checks++; if (t !== 10) begin errors++; $display("FAIL stall_latency got %0d want 10", t); end
        en = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid_hold got %0b want 1", bus.out_valid); end
        en = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_out_valid_drop got %0b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_busy_after got %0b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] yv;
        int lat;
        load_nominal();
        run_op(32'h0080_0000, 0, yv, lat);
        checks++; if (yv !== 32'h0080_0000) begin errors++; $display("FAIL b2b_first_y got %h want 00800000", yv); end
        for (int i = 0; i < 4; i++) begin vx[i] = '0; vw[i] = '0; end
        vx[0] = 32'hFFFF_FFFF; vw[0] = 32'h0000_0001;
        run_op(ONE, 0, yv, lat);
        checks++; if (yv !== 32'h00FF_FFFF) begin errors++; $display("FAIL b2b_second_y got %h want 00ffffff", yv); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_second_latency got %0d want 3", lat); end
        step();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bubbles();
        test_saturation();
        test_rst_mid();
        test_truncation();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate stage computing one neuron pre-activation, y = sat(bias + Σ x[i]·w[i]), over N_INPUTS serially streamed Q8.24 operand pairs. Sits directly upstream of the sigmoid activation: its `y` drives the activation's `a` input, and `out_valid` marks the sample to consume. One instance per neuron; the layer controller issues `start` and streams operands.

## Interface
- WIDTH, 32, operand/result width (signed two's complement)
- FL, 24, fractional bits (Q8.24)
- N_INPUTS, 4, operand pairs per accumulation (1..2^GUARD)
- GUARD, 8, accumulator headroom bits
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  global stall; low freezes every register and the FSM
- start  in  1  begin accumulation; sampled only in IDLE
- bias  in  WIDTH  Q8.24 bias, latched on accepted `start`
- in_valid  in  1  operand beat present
- x  in  WIDTH  Q8.24 input activation
- w  in  WIDTH  Q8.24 weight
- busy  out  1  high in every state except IDLE
- out_valid  out  1  one-cycle pulse, `y` holds a new result
- y  out  WIDTH  Q8.24 saturated pre-activation; held until next result

## Operation
- FSM: IDLE → ACC → FLUSH → FINISH → IDLE. Every transition requires en=1.
- IDLE: `start`=1 latches `bias`, clears accumulator, beat counter, and product register; next state ACC. `in_valid` ignored.
- ACC: beat accepted when in_valid=1. Product register ← (x·w) full 2·WIDTH signed, arithmetic shift right FL (floor, not round), kept at 2·WIDTH−FL bits. Accumulator (ACC_W = 2·WIDTH−FL+GUARD = 48 bits) adds previous product register each cycle a beat was accepted the cycle before. Counter 0..N_INPUTS−1; acceptance at N_INPUTS−1 → FLUSH. Bubbles (in_valid=0) allowed, add nothing.
- FLUSH: last product added into accumulator; → FINISH.
- FINISH: y ← sat(acc + sign-extended bias) to [0x80000000, 0x7FFFFFFF]; out_valid ← 1; → IDLE.
- `start` while busy: ignored. `in_valid` outside ACC: ignored, no side effects.
- No overflow wrap internally for N_INPUTS ≤ 2^GUARD; saturation only at output.

## Timing
- Reset values: state IDLE, busy 0, out_valid 0, y 0x00000000, accumulator/product/counter/bias 0.
- Latency: last beat presented in cycle k → out_valid=1 and new y in cycle k+3, en held high.
- out_valid high exactly one enabled cycle; with en=0 it holds its registered value, consumer qualifies with en (matches activation stage stall rule).
- Start-to-result minimum: start in cycle s, beats s+1..s+N_INPUTS, out_valid at s+N_INPUTS+3.
- en=0 anywhere: all state frozen; each stalled cycle extends latency by one, result unchanged.
- rst mid-operation: immediate abort to IDLE, no out_valid, y cleared.
- Back-to-back: `start` accepted in the cycle after FINISH (IDLE).

## Structure
- Shared package: WIDTH, FL, GUARD defaults, Q8.24 ONE (0x01000000), SAT_MAX 0x7FFFFFFF, SAT_MIN 0x80000000, FSM state encoding.
- One sub-module: `fx_mul` — signed WIDTH×WIDTH multiply with arithmetic shift by FL, registered output (product stage). Accumulator, counter, FSM, saturation in top.
- Pipeline/held registers use the team's standard register cell (clk, en, rst).

## Test plan
- Nominal: bias 0x00800000, x={0x01000000,0x02000000,0xFF800000,0x00400000}, w={0x00800000,0x00400000,0x01000000,0xFE000000} → y=0x00800000, out_valid at k+3, busy low after.
- Bubbles: same stream with in_valid low 2 cycles between each beat → identical y, out_valid 3 cycles after final beat.
- Saturation: x=w=0x7F000000 ×4, bias 0 → y=0x7FFFFFFF; w=0x81000000 → y=0x80000000.
- Truncation: beats (0xFFFFFFFF,0x00000001) then three (0,0), bias 0 → y=0xFFFFFFFF (floor); (0x00000001,0x00000001) → y=0x00000000.
- rst asserted after 2 accepted beats → busy 0, out_valid never pulses; fresh start yields clean nominal result.
- en low 3 cycles mid-ACC with in_valid high, plus `start` pulsed while busy → beats ignored while stalled, start ignored, result unchanged, latency +3.
